// File: rtl/spi_mem_sequencer.sv
// spi_mem_sequencer
//   Frame-level sequencer for the SPI-slave memory datapath. Runs on clk and
//   consumes conditioned chip-select plus single-cycle SCLK edge pulses.
//   A frame is an address byte (bit 0 = R/W, 0 = read, 1 = write) followed
//   by a data byte, either shifted out (read) or written to memory (write).
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   cs             conditioned chip select, active-low
//   sclk_pos       one-clk pulse per SCLK rising edge
//   sclk_neg       one-clk pulse per SCLK falling edge
//   shift_reg_out0 shift register bit 0 (R/W bit once the address is in)
//   addr_we        address latch write strobe (1 clk)
//   sr_we          shift register parallel-load strobe (1 clk)
//   dm_we          data memory write strobe (1 clk)
//   miso_buff      MISO tri-state enable during read data-out
//   busy           high whenever the sequencer is not IDLE
//   abort_count    [7:0] saturating count of mid-frame aborts
//                  (only when SPI_SEQ_ABORT_CNT_EN is defined)
//
// Optional feature macro: SPI_SEQ_ABORT_CNT_EN

module spi_mem_sequencer #(
  parameter int WORD_BITS = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk_pos,
  input  logic       sclk_neg,
  input  logic       shift_reg_out0,
`ifdef SPI_SEQ_ABORT_CNT_EN
  output logic [7:0] abort_count,
`endif
  output logic       addr_we,
  output logic       sr_we,
  output logic       dm_we,
  output logic       miso_buff,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, LATCH_ADDR, READ_LOAD, READ_OUT, WRITE_DATA, WRITE_MEM, DONE
  } state_t;

  localparam logic [CNT_W-1:0] WB = CNT_W'(WORD_BITS);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  // Outputs are registered alongside the state, so each strobe is high for
  // exactly the cycle its state is occupied. Strobes default low each clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_we   <= 1'b0;
      sr_we     <= 1'b0;
      dm_we     <= 1'b0;
      miso_buff <= 1'b0;
      busy      <= 1'b0;
    end else begin
      addr_we <= 1'b0;
      sr_we   <= 1'b0;
      dm_we   <= 1'b0;
      if (state != IDLE && cs) begin
        // Deselect wins over any edge pulse in the same clk.
        state     <= IDLE;
        cnt       <= '0;
        miso_buff <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!cs) begin
            state <= GET_ADDR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
          GET_ADDR: if (sclk_pos) begin
            cnt <= cnt_inc;
            if (cnt_inc == WB) begin
              state   <= LATCH_ADDR;
              addr_we <= 1'b1;
            end
          end
          LATCH_ADDR: begin
            cnt <= '0;
            if (shift_reg_out0) begin
              state <= WRITE_DATA;
            end else begin
              state <= READ_LOAD;
              sr_we <= 1'b1;
            end
          end
          READ_LOAD: begin
            state     <= READ_OUT;
            cnt       <= '0;
            miso_buff <= 1'b1;
          end
          READ_OUT: if (sclk_neg) begin
            cnt <= cnt_inc;
            if (cnt_inc == WB) begin
              state     <= DONE;
              miso_buff <= 1'b0;
            end
          end
          WRITE_DATA: if (sclk_pos) begin
            cnt <= cnt_inc;
            if (cnt_inc == WB) begin
              state <= WRITE_MEM;
              dm_we <= 1'b1;
            end
          end
          WRITE_MEM: state <= DONE;
          DONE:      ;  // hold until cs deasserts (handled above)
          default: begin
            state     <= IDLE;
            cnt       <= '0;
            miso_buff <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPI_SEQ_ABORT_CNT_EN
  // An abort is cs high while mid-frame; IDLE and DONE are not mid-frame.
  // The state leaves on the same clk, so each cs rise counts once.
  logic abort_evt;
  assign abort_evt = cs && (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             abort_count <= '0;
    else if (abort_evt && abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_mem_sequencer.sv
module tb_spi_mem_sequencer;

  logic clk = 1'b0;
  logic reset, cs, sclk_pos, sclk_neg, shift_reg_out0;
  logic addr_we, sr_we, dm_we, miso_buff, busy;
`ifdef SPI_SEQ_ABORT_CNT_EN
  logic [7:0] abort_count;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n_addr = 0, n_sr = 0, n_dm = 0;

  always #5 clk = ~clk;

  spi_mem_sequencer #(.WORD_BITS(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .shift_reg_out0(shift_reg_out0),
`ifdef SPI_SEQ_ABORT_CNT_EN
    .abort_count(abort_count),
`endif
    .addr_we(addr_we), .sr_we(sr_we), .dm_we(dm_we), .miso_buff(miso_buff), .busy(busy)
  );

  // strobe-cycle counters, sampled on the falling edge
  always @(negedge clk) begin
    if (addr_we) n_addr++;
    if (sr_we)   n_sr++;
    if (dm_we)   n_dm++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clk; inputs are driven and outputs sampled 1 ns after the falling edge
  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic edge_pulse(input logic p, input logic n);
    sclk_pos = p; sclk_neg = n;
    cyc();
    sclk_pos = 1'b0; sclk_neg = 1'b0;
  endtask

  // cs low, then n address/data pos edges spaced 4 clk apart
  task automatic pos_edges(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) idle(3);
      edge_pulse(1'b1, 1'b0);
    end
  endtask

  task automatic addr_phase(input logic rw);
    shift_reg_out0 = rw;
    cs = 1'b0;
    cyc();
    chk("busy_get_addr", busy, 1);
    pos_edges(7);
    idle(3);
    chk("addr_we_pre", addr_we, 0);
    edge_pulse(1'b1, 1'b0);
    chk("addr_we_pulse", addr_we, 1);
  endtask

  task automatic read_frame();
    int a0, d0;
    a0 = n_addr; d0 = n_dm;
    addr_phase(1'b0);
    cyc();
    chk("rd_addr_we_drop", addr_we, 0);
    chk("rd_sr_we", sr_we, 1);
    cyc();
    chk("rd_sr_we_drop", sr_we, 0);
    chk("rd_miso_on", miso_buff, 1);
    for (int i = 0; i < 8; i++) begin
      idle(3);
      chk("rd_miso_hold", miso_buff, 1);
      edge_pulse(1'b0, 1'b1);
    end
    chk("rd_miso_off", miso_buff, 0);
    chk("rd_busy_done", busy, 1);
    chk("rd_addr_cnt", n_addr - a0, 1);
    chk("rd_dm_none", n_dm - d0, 0);
    cs = 1'b1;
    cyc();
    chk("rd_busy_idle", busy, 0);
  endtask

  initial begin
    int a0, s0, d0;
    reset = 1'b1; cs = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; shift_reg_out0 = 1'b0;
    idle(2);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {addr_we, sr_we, dm_we, miso_buff}, 0);
    reset = 1'b0;
    idle(2);
    chk("idle_busy", busy, 0);
`ifdef SPI_SEQ_ABORT_CNT_EN
    chk("abort_cnt_rst", abort_count, 0);
`endif

    // read frame with extra SCLK in DONE
    s0 = n_sr;
    addr_phase(1'b0);
    idle(2);
    for (int i = 0; i < 8; i++) begin idle(3); edge_pulse(1'b0, 1'b1); end
    chk("done_busy", busy, 1);
    a0 = n_addr; d0 = n_dm;
    pos_edges(4);
    idle(2);
    chk("done_extra_busy", busy, 1);
    chk("done_extra_strobes", (n_addr - a0) + (n_dm - d0) + miso_buff, 0);
    chk("sr_once", n_sr - s0, 1);
    cs = 1'b1; cyc();
    chk("done_to_idle", busy, 0);
    idle(2);

    read_frame();
    idle(2);

    // write frame
    s0 = n_sr; d0 = n_dm;
    addr_phase(1'b1);
    cyc();
    chk("wr_addr_we_drop", addr_we, 0);
    chk("wr_no_sr", sr_we, 0);
    pos_edges(7);
    idle(3);
    chk("wr_dm_pre", dm_we, 0);
    edge_pulse(1'b1, 1'b0);
    chk("wr_dm_pulse", dm_we, 1);
    cyc();
    chk("wr_dm_drop", dm_we, 0);
    chk("wr_busy_done", busy, 1);
    chk("wr_dm_cnt", n_dm - d0, 1);
    chk("wr_sr_none", n_sr - s0, 0);
    chk("wr_miso", miso_buff, 0);
    cs = 1'b1; cyc();
    chk("wr_idle", busy, 0);
    idle(2);

    // abort after 5th data edge of a write
    d0 = n_dm;
    addr_phase(1'b1);
    cyc();
    pos_edges(5);
    idle(2);
    cs = 1'b1; cyc();
    chk("abort_idle", busy, 0);
    idle(4);
    chk("abort_no_dm", n_dm - d0, 0);
`ifdef SPI_SEQ_ABORT_CNT_EN
    chk("abort_cnt_1", abort_count, 1);
`endif

    // cs rise coincident with 8th address edge
    a0 = n_addr;
    shift_reg_out0 = 1'b0;
    cs = 1'b0; cyc();
    pos_edges(7);
    idle(3);
    cs = 1'b1;
    edge_pulse(1'b1, 1'b0);
    chk("prio_busy", busy, 0);
    chk("prio_addr_we", addr_we, 0);
    idle(3);
    chk("prio_addr_cnt", n_addr - a0, 0);
`ifdef SPI_SEQ_ABORT_CNT_EN
    chk("abort_cnt_2", abort_count, 2);
`endif

    // async reset mid READ_OUT
    addr_phase(1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) begin idle(3); edge_pulse(1'b0, 1'b1); end
    chk("mid_miso", miso_buff, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_miso", miso_buff, 0);
    chk("arst_busy", busy, 0);
    cs = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);
`ifdef SPI_SEQ_ABORT_CNT_EN
    chk("abort_cnt_clr", abort_count, 0);
`endif
    read_frame();

`ifdef SPI_SEQ_ABORT_CNT_EN
    for (int i = 0; i < 300; i++) begin
      cs = 1'b0; cyc();
      cs = 1'b1; cyc();
    end
    chk("abort_cnt_sat", abort_count, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
